// File: rtl/prod_acc_pkg.sv
// Shared types and default sizing for the product accumulator.
// Imported by the interface, the adder and the top.
package prod_acc_pkg;

    localparam int PROD_W  = 7;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 9;
    localparam int CNT_W   = $clog2(N_TERMS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/prod_acc_if.sv
// Handshake bundle between the multiplier side, the accumulator
// and the consumer of the frame total.
interface prod_acc_if
    import prod_acc_pkg::*;
();

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              busy;

    modport master (
        output start,
        output in_valid,
        output in_prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  busy
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output busy
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/prod_acc_add.sv
// Combinational ripple-carry adder chained from full_adder cells.
module prod_acc_add
    import prod_acc_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);

    logic [W:0] c;

    assign c[0] = ci_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a  (a_i[i]),
            .b  (b_i[i]),
            .ci (c[i]),
            .s  (s_o[i]),
            .co (c[i+1])
        );
    end

    assign co_o = c[W];

endmodule

// File: rtl/prod_accumulator.sv
// Frame accumulator: sums N_TERMS products and presents the total
// on a held valid/ready output.
module prod_accumulator
    import prod_acc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    prod_acc_if.slave  bus
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ACC_W-1:0] sum;
    logic             unused_co;
    logic             in_ready;
    logic             accept;

    prod_acc_add #(.W(ACC_W)) u_add (
        .a_i  (acc_q),
        .b_i  ({{(ACC_W-PROD_W){1'b0}}, bus.in_prod}),
        .ci_i (1'b0),
        .s_o  (sum),
        .co_o (unused_co)
    );

    // in_ready never depends on in_valid, so start always wins
    assign in_ready = (state_q == ACCUM) && !bus.start;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (bus.start) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_TERMS - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_prod_accumulator.sv
// Randomized and directed frames checked against a sum/latency model.
module tb_prod_accumulator;
    import prod_acc_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   t0;
    int   tv[N_TERMS];
    int   tg[N_TERMS];

    prod_acc_if bus ();

    prod_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic open_frame();
        bus.start = 1'b1;
        #1;
        chk("start_in_ready", int'(bus.in_ready), 0);
        t0 = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input int v, input int gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_prod  = PROD_W'($urandom);
            #1;
            chk("gap_in_ready", int'(bus.in_ready), 1);
            chk("gap_out_valid", int'(bus.out_valid), 0);
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_prod  = PROD_W'(v);
        #1;
        chk("in_ready", int'(bus.in_ready), 1);
        chk("busy", int'(bus.busy), 1);
        chk("early_out_valid", int'(bus.out_valid), 0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Model: total = plain sum of terms; latency = N_TERMS+1 plus idle cycles
    task automatic run_frame(input int hold, input bit nxt);
        int s;
        int g;
        s = 0;
        g = 0;
        for (int i = 0; i < N_TERMS; i++) begin
            s += tv[i];
            g += tg[i];
            feed(tv[i], tg[i]);
        end
        chk("out_valid", int'(bus.out_valid), 1);
        chk("latency", cyc - t0, N_TERMS + 1 + g);
        chk("out_sum", int'(bus.out_sum), s);
        repeat (hold) begin
            bus.out_ready = 1'b0;
            bus.start     = 1'($urandom_range(1));
            #1;
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_out_sum", int'(bus.out_sum), s);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        bus.start     = nxt;
        if (nxt) t0 = cyc;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("busy_after", int'(bus.busy), int'(nxt));
        chk("out_valid_after", int'(bus.out_valid), 0);
    endtask

    task automatic set_terms(input int a, input int b, input int c, input int d);
        tv[0] = a; tv[1] = b; tv[2] = c; tv[3] = d;
        for (int i = 0; i < N_TERMS; i++) tg[i] = 0;
    endtask

    initial begin
        bit pend;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        t0            = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores in_valid and out_ready
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("idle_busy", int'(bus.busy), 0);

        set_terms(6, 15, 105, 0);
        open_frame();
        run_frame(0, 1'b0);

        set_terms(105, 105, 105, 105);
        open_frame();
        run_frame(0, 1'b0);

        set_terms(1, 2, 3, 4);
        tg[2] = 2;
        open_frame();
        run_frame(5, 1'b0);

        // Abort mid-frame, then back-to-back frames
        open_frame();
        feed(50, 0);
        feed(50, 0);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_prod  = PROD_W'(50);
        #1;
        chk("abort_in_ready", int'(bus.in_ready), 0);
        t0 = cyc;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        set_terms(1, 2, 3, 4);
        run_frame(0, 1'b1);
        set_terms(5, 5, 5, 5);
        run_frame(0, 1'b0);

        // Asynchronous reset between edges after two accepts
        open_frame();
        feed(1, 0);
        feed(1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_out_sum", int'(bus.out_sum), 0);
        chk("arst_in_ready", int'(bus.in_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_no_valid", int'(bus.out_valid), 0);
        set_terms(1, 1, 1, 1);
        open_frame();
        run_frame(0, 1'b0);

        // Random frames from 4x3 multiplier products
        pend = 1'b0;
        for (int f = 0; f < 30; f++) begin
            bit nxt;
            for (int i = 0; i < N_TERMS; i++) begin
                tv[i] = $urandom_range(15) * $urandom_range(7);
                tg[i] = ($urandom_range(3) == 0) ? $urandom_range(2) : 0;
            end
            nxt = (f < 29) ? 1'($urandom_range(1)) : 1'b0;
            if (!pend) open_frame();
            run_frame($urandom_range(3), nxt);
            pend = nxt;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Sequential accumulator directly downstream of the 4x3 array multiplier. It consumes a frame of N_TERMS 7-bit products over a valid/ready handshake and sums them into a wider register. It presents the frame total on a registered valid/ready output, forming a multiply-accumulate (dot-product) path with the multiplier. One clock domain; the multiplier stays purely combinational in front of it.

## Interface
- PROD_W, 7, product width; matches the multiplier output C[6:0]
- N_TERMS, 4, products per frame; must be 2 or more
- ACC_W, 9, accumulator width; must be at least PROD_W + ceil(log2(N_TERMS)), so the sum never overflows
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle pulse; opens a new frame and clears the accumulator
- in_valid  in  1  in_prod holds a valid product
- in_ready  out  1  block accepts in_prod this cycle
- in_prod  in  PROD_W  product from the multiplier
- out_valid  out  1  out_sum holds the completed frame total
- out_ready  in  1  downstream takes out_sum
- out_sum  out  ACC_W  frame total, registered
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCUM, DONE. Registered state: state, acc[ACC_W-1:0], cnt[ceil(log2(N_TERMS))-1:0].
- Accept event = in_valid && in_ready.
- in_ready = (state == ACCUM) && !start. It is combinational from state and start only, never from in_valid.
- IDLE:
  - start moves to ACCUM and sets acc <= 0, cnt <= 0.
  - in_valid and out_ready are ignored.
- ACCUM:
  - Each accept: acc <= acc + zero-extended in_prod, cnt <= cnt + 1.
  - Accept while cnt == N_TERMS-1: move to DONE; acc takes the final sum.
  - start restarts the frame (abort): acc <= 0, cnt <= 0, stay in ACCUM. The product presented that cycle is not accepted.
- DONE:
  - out_valid = 1 and out_sum = acc.
  - out_ready && !start: go to IDLE.
  - out_ready && start: go to ACCUM with acc <= 0, cnt <= 0 (back-to-back frames).
  - start without out_ready is ignored; the result is held.
- Arithmetic is unsigned, with no saturation or wrap because ACC_W is sized for the worst case.
- out_sum drives acc directly. Outside DONE its value is don't-care, but it must not be X after reset.

## Timing
- Reset (async assert, sync release): state = IDLE, acc = 0, cnt = 0, in_ready = 0, out_valid = 0, out_sum = 0, busy = 0.
- Reset asserted mid-frame discards the partial sum immediately. No out_valid follows.
- Latency with no stalls:
  - start in cycle t.
  - Accepts in cycles t+1 through t+N_TERMS.
  - out_valid high from cycle t+N_TERMS+1.
- in_valid gaps stretch the frame one cycle per idle cycle. Only accepts advance cnt.
- out_valid, once high, stays high with out_sum stable until the cycle where out_ready is sampled high.
- Shortest frame-to-frame spacing is N_TERMS+1 cycles, achieved by pulsing start together with out_ready in DONE.

## Structure
- Shared package prod_acc_pkg holds:
  - state enum acc_state_t {IDLE, ACCUM, DONE}
  - default constants PROD_W = 7, N_TERMS = 4, ACC_W = 9
- One sub-module, prod_acc_add: a combinational ACC_W-bit ripple-carry adder built from the existing full_adder cell. Port A is acc; port B is in_prod zero-extended; carry-in is 0; carry-out is unused.
- The FSM, counter and registers live in prod_accumulator.

## Test plan
- Basic frame: reset, start, then products 6, 15, 105, 0 on consecutive cycles. Required: out_valid exactly 5 cycles after start, out_sum = 126, busy high throughout.
- Worst case: four products of 105 (7 x 15). Required: out_sum = 420 with no overflow, using ACC_W = 9.
- Input and output stalls:
  - in_valid low for 2 cycles between terms of 1, 2, 3, 4. Required: out_valid at start + 7, out_sum = 10.
  - Then hold out_ready low for 5 cycles. Required: out_valid and out_sum = 10 held unchanged, return to IDLE the cycle after out_ready rises.
- Abort and back-to-back:
  - Feed 50, 50, then start with in_valid high, then 1, 2, 3, 4. Required: in_ready low in the start cycle, out_sum = 10.
  - In DONE, pulse start and out_ready together, then feed 5 x4. Required: second out_sum = 20 with no IDLE cycle in between.
- Async reset mid-frame: drop rst_n between clock edges after two accepts. Required: all outputs go to reset values immediately, no out_valid, and the next frame of 1, 1, 1, 1 gives out_sum = 4.
